// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD frame sequencer: mode/state encodings,
// control characters and the fixed message texts.
package lcd_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_CONGRAT = 2'd1,
    MODE_SET     = 2'd2,
    MODE_GUESS   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_LBRACKET = 8'h5B;
  localparam logic [7:0] CH_J        = 8'h6A;
  localparam logic [7:0] CH_SPACE    = 8'h20;

  localparam int unsigned TXT_CONGRAT_LEN = 15;
  localparam int unsigned TXT_SET_LEN     = 8;
  localparam int unsigned TXT_GUESS_LEN   = 10;

  localparam logic [8*TXT_CONGRAT_LEN-1:0] TXT_CONGRAT = "CONGRATULATIONS";
  localparam logic [8*TXT_SET_LEN-1:0]     TXT_SET     = " ANS SET";
  localparam logic [8*TXT_GUESS_LEN-1:0]   TXT_GUESS   = " TRY AGAIN";

  // Character pos of the mode's fixed text; anything past the end reads as a space.
  function automatic logic [7:0] text_char(input mode_t m, input int unsigned pos);
    logic [7:0] ch;
    ch = CH_SPACE;
    case (m)
      MODE_CONGRAT: if (pos < TXT_CONGRAT_LEN) ch = TXT_CONGRAT[8*(TXT_CONGRAT_LEN-1-pos) +: 8];
      MODE_SET:     if (pos < TXT_SET_LEN)     ch = TXT_SET[8*(TXT_SET_LEN-1-pos) +: 8];
      MODE_GUESS:   if (pos < TXT_GUESS_LEN)   ch = TXT_GUESS[8*(TXT_GUESS_LEN-1-pos) +: 8];
      default:      ch = CH_SPACE;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// Byte-level link between the frame sequencer (master) and the SPI byte transmitter (slave).
interface lcd_frame_sequencer_if;
    logic [7:0] byte_out;
    logic       byte_start;
    logic       slave_sel;
    logic       byte_done;

    modport master (
        output byte_out,
        output byte_start,
        output slave_sel,
        input  byte_done
    );

    modport slave (
        input  byte_out,
        input  byte_start,
        input  slave_sel,
        output byte_done
    );
endinterface

// File: rtl/lcd_digit_ascii.sv
// Maps one value nibble to its display character; C-F have no glyph and show blank.
module lcd_digit_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = CH_SPACE;
        if (nibble <= 4'd9)       ascii = {4'h3, nibble};
        else if (nibble == 4'hA)  ascii = 8'h41;
        else if (nibble == 4'hB)  ascii = 8'h42;
    end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Builds an LCD clear-and-print frame from a captured mode/value, streams it byte by
// byte over the SPI handshake, holds the message, then pulses done.
module lcd_frame_sequencer
    import lcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_CHARS   = 16,
    parameter int HOLD_CYCLES = 125_000_000,
    parameter int CNT_W       = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [4*NUM_DIGITS-1:0] value,
    lcd_frame_sequencer_if.master   spi,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              state
);

    localparam int FRAME_LEN = 3 + MSG_CHARS;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    mode_t                   mode_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [CNT_W-1:0]        hold_cnt_q;
    logic [7:0]              byte_q;
    logic [7:0]              digit_ascii [NUM_DIGITS];
    logic [7:0]              frame_byte;
    logic                    last_byte;
    logic                    hold_end;
    logic                    byte_start_c;
    logic                    slave_sel_c;

    assign last_byte = (idx_q == LAST_IDX);
    assign hold_end  = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Digit 0 is the leftmost character, taken from the most significant nibble.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        lcd_digit_ascii u_digit (
            .nibble (value_q[4*(NUM_DIGITS-1-g) +: 4]),
            .ascii  (digit_ascii[g])
        );
    end

    always_comb begin
        int unsigned c;
        c          = 0;
        frame_byte = CH_SPACE;
        if (idx_q == IDX_W'(0))      frame_byte = CH_ESC;
        else if (idx_q == IDX_W'(1)) frame_byte = CH_LBRACKET;
        else if (idx_q == IDX_W'(2)) frame_byte = CH_J;
        else begin
            c = 32'(idx_q) - 32'd3;
            if (mode_q == MODE_CONGRAT) begin
                frame_byte = text_char(mode_q, c);
            end else if (c < NUM_DIGITS) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (c == unsigned'(i)) frame_byte = digit_ascii[i];
            end else begin
                frame_byte = text_char(mode_q, c - NUM_DIGITS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: if (spi.byte_done) state_d = last_byte ? ST_HOLD : ST_SEND;
            ST_HOLD: if (hold_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_start_c = (state_q == ST_SEND);
        slave_sel_c  = !((state_q == ST_SEND) || (state_q == ST_WAIT));
        busy         = (state_q == ST_LOAD) || (state_q == ST_SEND) ||
                       (state_q == ST_WAIT) || (state_q == ST_HOLD);
        done         = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            hold_cnt_q <= '0;
            byte_q     <= 8'h00;
        end else begin
            if (state_q == ST_LOAD)
                idx_q <= '0;
            else if ((state_q == ST_WAIT) && spi.byte_done && !last_byte)
                idx_q <= idx_q + 1'b1;

            if ((state_q == ST_HOLD) && !hold_end) hold_cnt_q <= hold_cnt_q + 1'b1;
            else                                   hold_cnt_q <= '0;

            if (state_q == ST_SEND) byte_q <= frame_byte;
        end
    end

    // Shadow copies isolate the frame in flight from later input changes.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            mode_q  <= mode_t'(mode);
            value_q <= value;
        end
    end

    // During SEND the fresh frame byte is shown directly; byte_q keeps it stable afterwards.
    assign spi.byte_out   = (state_q == ST_SEND) ? frame_byte : byte_q;
    assign spi.byte_start = byte_start_c;
    assign spi.slave_sel  = slave_sel_c;
    assign state          = state_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench: a 16-char and an 8-char sequencer, table vectors, corner
// sequences and randomized frames against a string-level message model.
module tb_lcd_frame_sequencer;

    typedef struct {
        bit         on_b;
        logic [1:0] m;
        logic [15:0] v;
        string      line;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] value = 16'h0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [2:0]  state_a, state_b;
    logic        bd_resp_a = 1'b0, bd_spur_a = 1'b0, bd_resp_b = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dly_a = 4, dly_b = 4;
    int pend_a = 0, pend_b = 0;
    int last_bd_a = 0, last_bd_b = 0;
    int rises_a = 0, rises_b = 0, badsel_a = 0, badsel_b = 0;
    logic prev_sel_a = 1'b1, prev_sel_b = 1'b1;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    vec_t vecs[9];

    lcd_frame_sequencer_if ifa ();
    lcd_frame_sequencer_if ifb ();

    assign ifa.byte_done = bd_resp_a | bd_spur_a;
    assign ifb.byte_done = bd_resp_b;

    lcd_frame_sequencer #(.NUM_DIGITS(4), .MSG_CHARS(16), .HOLD_CYCLES(10), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .value(value),
        .spi(ifa), .busy(busy_a), .done(done_a), .state(state_a));

    lcd_frame_sequencer #(.NUM_DIGITS(4), .MSG_CHARS(8), .HOLD_CYCLES(10), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .value(value),
        .spi(ifb), .busy(busy_b), .done(done_b), .state(state_b));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI transmitter stand-in plus byte capture, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        bd_resp_a = 1'b0;
        bd_resp_b = 1'b0;
        if (rst) begin
            pend_a = 0;
            pend_b = 0;
        end
        if (ifa.byte_start) begin
            qa.push_back(ifa.byte_out);
            if (ifa.slave_sel) badsel_a++;
        end
        if (ifb.byte_start) begin
            qb.push_back(ifb.byte_out);
            if (ifb.slave_sel) badsel_b++;
        end
        if (ifa.slave_sel && !prev_sel_a) rises_a++;
        if (ifb.slave_sel && !prev_sel_b) rises_b++;
        prev_sel_a = ifa.slave_sel;
        prev_sel_b = ifb.slave_sel;
        if (pend_a > 0) begin
            pend_a--;
            if (pend_a == 0) begin bd_resp_a = 1'b1; last_bd_a = cyc; end
        end else if (ifa.byte_start && !rst) pend_a = dly_a;
        if (pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) begin bd_resp_b = 1'b1; last_bd_b = cyc; end
        end else if (ifb.byte_start && !rst) pend_b = dly_b;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Message text as a person would read it off the display, before framing.
    function automatic string exp_line(input logic [1:0] m, input logic [15:0] v, input int nch);
        string dig, s;
        logic [3:0] nib;
        dig = "";
        for (int i = 0; i < 4; i++) begin
            nib = v[15-4*i -: 4];
            if (nib < 4'd10)      dig = $sformatf("%s%0d", dig, nib);
            else if (nib == 4'hA) dig = {dig, "A"};
            else if (nib == 4'hB) dig = {dig, "B"};
            else                  dig = {dig, " "};
        end
        case (m)
            2'd0:    s = dig;
            2'd1:    s = "CONGRATULATIONS";
            2'd2:    s = {dig, " ANS SET"};
            default: s = {dig, " TRY AGAIN"};
        endcase
        while (s.len() < nch) s = {s, " "};
        return s.substr(0, nch - 1);
    endfunction

    // disturb bit0: start pulses in WAIT/HOLD/DONE and input changes; bit1: spurious byte_done.
    task automatic run_frame(input bit on_b, input logic [1:0] m, input logic [15:0] v,
                             input int dly, input int disturb, input string line, input string tag);
        int s, first_bs, done_cyc, ndone, lastbd, n_got;
        logic bs, dn;
        logic [2:0] st;
        logic [7:0] want;
        if (on_b) dly_b = dly; else dly_a = dly;
        mode  = m;
        value = v;
        if (disturb[1]) begin
            @(negedge clk); bd_spur_a = 1'b1;
            @(negedge clk); bd_spur_a = 1'b0;
        end
        @(negedge clk);
        qa.delete(); qb.delete();
        rises_a = 0; rises_b = 0; badsel_a = 0; badsel_b = 0;
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        s = cyc;
        first_bs = -1; done_cyc = -1; ndone = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; bd_spur_a = 1'b0;
            bs = on_b ? ifb.byte_start : ifa.byte_start;
            dn = on_b ? done_b : done_a;
            st = on_b ? state_b : state_a;
            if (bs && first_bs < 0) first_bs = cyc;
            if (dn) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
            if (disturb[0]) begin
                if (st == 3'd3 && (n % 7) == 3) begin start_a = 1'b1; value = ~value; mode = mode + 2'd1; end
                if (st == 3'd4 || dn) start_a = 1'b1;
            end
            if (disturb[1] && st == 3'd4 && (n % 3) == 0) bd_spur_a = 1'b1;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end
        start_a = 1'b0; start_b = 1'b0; bd_spur_a = 1'b0;
        lastbd = on_b ? last_bd_b : last_bd_a;
        check({tag, " done_pulses"}, ndone, 1);
        check({tag, " start_to_byte_start"}, first_bs - s, 2);
        check({tag, " last_byte_done_to_done"}, done_cyc - lastbd, 11);
        check({tag, " sel_release_count"}, on_b ? rises_b : rises_a, 1);
        check({tag, " sel_high_at_byte_start"}, on_b ? badsel_b : badsel_a, 0);
        check({tag, " busy_after_done"}, on_b ? busy_b : busy_a, 0);
        check({tag, " state_after_done"}, on_b ? state_b : state_a, 0);
        n_got = on_b ? qb.size() : qa.size();
        check({tag, " frame_len"}, n_got, 3 + line.len());
        for (int i = 0; i < 3 + line.len(); i++) begin
            if (i == 0)      want = 8'h1B;
            else if (i == 1) want = 8'h5B;
            else if (i == 2) want = 8'h6A;
            else             want = line[i-3];
            if (i < n_got) check($sformatf("%s byte%0d", tag, i), on_b ? qb[i] : qa[i], want);
        end
    endtask

    initial begin
        int cnt, n;
        bit hit;
        logic [1:0]  rm;
        logic [15:0] rv;

        vecs[0] = '{1'b0, 2'd0, 16'h12AB, "12AB            "};
        vecs[1] = '{1'b0, 2'd1, 16'h5555, "CONGRATULATIONS "};
        vecs[2] = '{1'b0, 2'd2, 16'h9C0F, "9 0  ANS SET    "};
        vecs[3] = '{1'b0, 2'd3, 16'h0009, "0009 TRY AGAIN  "};
        vecs[4] = '{1'b0, 2'd0, 16'hBA90, "BA90            "};
        vecs[5] = '{1'b0, 2'd2, 16'hEDCB, "   B ANS SET    "};
        vecs[6] = '{1'b1, 2'd3, 16'h0009, "0009 TRY"};
        vecs[7] = '{1'b1, 2'd1, 16'h0000, "CONGRATU"};
        vecs[8] = '{1'b1, 2'd2, 16'h1A2B, "1A2B ANS"};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset state", state_a, 0);
        check("reset byte_out", ifa.byte_out, 8'h00);
        check("reset byte_start", ifa.byte_start, 0);
        check("reset slave_sel", ifa.slave_sel, 1);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset state_b", state_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_frame(vecs[i].on_b, vecs[i].m, vecs[i].v, 4, 0, vecs[i].line, $sformatf("vec%0d", i));

        run_frame(1'b0, 2'd0, 16'h12AB, 3, 1, "12AB            ", "ignore_start");
        run_frame(1'b0, 2'd3, 16'hA0B1, 4, 2, "A0B1 TRY AGAIN  ", "spurious_done");

        // Abort a frame part-way through with reset, then send a clean one.
        mode = 2'd0; value = 16'h4321; dly_a = 2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cnt = 0; hit = 1'b0;
        for (n = 0; n < 500 && !hit; n++) begin
            if (ifa.byte_start) begin
                cnt++;
                if (cnt == 6) hit = 1'b1;
            end
            if (!hit) @(negedge clk);
        end
        check("reset_abort reached_byte6", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort state", state_a, 0);
        check("reset_abort slave_sel", ifa.slave_sel, 1);
        check("reset_abort byte_start", ifa.byte_start, 0);
        check("reset_abort busy", busy_a, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_frame(1'b0, 2'd0, 16'h4321, 4, 0, "4321            ", "after_reset");

        for (int r = 0; r < 10; r++) begin
            rm = 2'($urandom_range(0, 3));
            rv = 16'($urandom);
            run_frame(1'b0, rm, rv, int'($urandom_range(1, 5)), 0, exp_line(rm, rv, 16),
                      $sformatf("rnd_a%0d", r));
        end
        for (int r = 0; r < 4; r++) begin
            rm = 2'($urandom_range(0, 3));
            rv = 16'($urandom);
            run_frame(1'b1, rm, rv, int'($urandom_range(1, 5)), 0, exp_line(rm, rv, 8),
                      $sformatf("rnd_b%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
